// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory front end: default widths,
// port-select codes and the arbiter FSM state encoding.
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    // Port-select codes, also used as the round-robin grant value
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Arbiter FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_ACK   = 2'd3;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker. On a tie, the port that was not granted
// last wins. The last-grant register is preset so that the first tie after
// reset goes to the port chosen by DATA_FIRST.
import cpu_mem_pkg::*;

module rr_arb2 #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       valid_o,
    output logic       port_o
);

    logic last_q;
    logic last_d;

    // Winner selection and last-grant update
    always_comb begin
        valid_o = req_i[PORT_IF] | req_i[PORT_D];
        if (req_i[PORT_IF] & req_i[PORT_D]) begin
            port_o = ~last_q;
        end else begin
            port_o = req_i[PORT_D];
        end
        last_d = (take_i & valid_o) ? port_o : last_q;
    end

    // Last-grant register; preset to the loser of the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= DATA_FIRST ? PORT_IF : PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port front end for the single-ported word memory. Serialises
// instruction fetches and data loads/stores onto the memory start/ready
// handshake and returns one-cycle acks with registered read data.
//
// state | meaning
// IDLE  | waiting for a request while memory is ready; grant and latch
// ISSUE | mem_start high for this one cycle
// WAIT  | memory busy; capture read data when mem_ready returns
// ACK   | granted port's ack high for this one cycle
import cpu_mem_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_rwn,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_start,
    output logic              mem_rwn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ready
);

    state_t            state_q,       state_d;
    logic              port_q,        port_d;
    logic              mem_start_q,   mem_start_d;
    logic              mem_rwn_q,     mem_rwn_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              if_ack_q,      if_ack_d;
    logic              d_ack_q,       d_ack_d;
    logic [DATA_W-1:0] if_rdata_q,    if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,     d_rdata_d;

    logic arb_valid;
    logic arb_port;
    logic arb_take;

    rr_arb2 #(
        .DATA_FIRST (DATA_FIRST)
    ) u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req_i   ({d_req, if_req}),
        .take_i  (arb_take),
        .valid_o (arb_valid),
        .port_o  (arb_port)
    );

    // Next-state logic for the FSM and all registered outputs
    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        mem_start_d   = 1'b0;
        mem_rwn_d     = mem_rwn_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        if_ack_d      = 1'b0;
        d_ack_d       = 1'b0;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        arb_take      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid & mem_ready) begin
                    arb_take    = 1'b1;
                    port_d      = arb_port;
                    mem_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                    if (arb_port == PORT_D) begin
                        mem_address_d = d_addr;
                        mem_rwn_d     = d_rwn;
                        mem_data_in_d = d_wdata;
                    end else begin
                        mem_address_d = if_addr;
                        mem_rwn_d     = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_ACK;
                    if (port_q == PORT_D) begin
                        d_ack_d = 1'b1;
                        if (mem_rwn_q) begin
                            d_rdata_d = mem_data_out;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_data_out;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            port_q        <= PORT_IF;
            mem_start_q   <= 1'b0;
            mem_rwn_q     <= 1'b1;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            port_q        <= port_d;
            mem_start_q   <= mem_start_d;
            mem_rwn_q     <= mem_rwn_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            if_ack_q      <= if_ack_d;
            d_ack_q       <= d_ack_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    assign mem_start   = mem_start_q;
    assign mem_rwn     = mem_rwn_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign if_ack      = if_ack_q;
    assign d_ack       = d_ack_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural word memory whose
// busy time is mem_address[1:0]+1 cycles after the start edge.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_rwn = 1'b1;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_start;
    logic          mem_rwn;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_ready;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .DATA_FIRST (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_rwn        (d_rwn),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .mem_start    (mem_start),
        .mem_rwn      (mem_rwn),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready)
    );

    typedef struct {
        bit            port;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    logic [DW-1:0] got_mon;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int start_cnt = 0;
    int if_ack_cnt = 0;
    int d_ack_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model
    logic [DW-1:0] mem [256];
    bit            loaded = 1'b0;
    logic [DW-1:0] rd_q;
    logic [2:0]    busy;
    logic          ready_q;
    logic [DW-1:0] dout_q;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b1;
            busy    <= '0;
            dout_q  <= '0;
            rd_q    <= '0;
            if (!loaded) begin
                for (int i = 0; i < 256; i++) mem[i] <= '0;
                mem[2]  <= 16'h0005;
                mem[3]  <= 16'h0000;
                mem[4]  <= 16'h000B;
                mem[10] <= 16'h9880;
                loaded  <= 1'b1;
            end
        end else if (mem_start) begin
            if (!mem_rwn) mem[mem_address] <= mem_data_in;
            rd_q    <= mem_rwn ? mem[mem_address] : mem_data_in;
            busy    <= {1'b0, mem_address[1:0]} + 3'd1;
            ready_q <= 1'b0;
        end else if (busy != 3'd0) begin
            busy <= busy - 3'd1;
            if (busy == 3'd1) begin
                ready_q <= 1'b1;
                dout_q  <= rd_q;
            end
        end
    end

    assign mem_ready    = ready_q;
    assign mem_data_out = dout_q;

    // Scoreboard: every ack pops the oldest expectation and is compared
    always @(negedge clk) begin
        if (mem_start) start_cnt++;
        if (if_ack) if_ack_cnt++;
        if (d_ack) d_ack_cnt++;
        if (if_ack || d_ack) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: cycle %0d if_ack=%0b d_ack=%0b, required no ack", cyc, if_ack, d_ack);
            end else begin
                e_mon = exp_q.pop_front();
                n_checks++;
                if ({if_ack, d_ack} !== (e_mon.port ? 2'b01 : 2'b10))
                    $display("FAIL ack_port: got {if_ack,d_ack}=%b, required port %0d", {if_ack, d_ack}, e_mon.port);
                else n_pass++;
                n_checks++;
                if (cyc !== e_mon.cyc)
                    $display("FAIL ack_cycle: got cycle %0d, required %0d", cyc, e_mon.cyc);
                else n_pass++;
                got_mon = e_mon.port ? d_rdata : if_rdata;
                n_checks++;
                if (got_mon !== e_mon.rdata)
                    $display("FAIL ack_rdata: port %0d got %h, required %h", e_mon.port, got_mon, e_mon.rdata);
                else n_pass++;
            end
        end
    end

    task automatic wait_ack(input bit port, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (port ? d_ack : if_ack) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (if_ack !== 1'b0) $display("FAIL rst_if_ack: got %b, required 0", if_ack); else n_pass++;
        n_checks++; if (d_ack !== 1'b0) $display("FAIL rst_d_ack: got %b, required 0", d_ack); else n_pass++;
        n_checks++; if (if_rdata !== 16'h0) $display("FAIL rst_if_rdata: got %h, required 0000", if_rdata); else n_pass++;
        n_checks++; if (d_rdata !== 16'h0) $display("FAIL rst_d_rdata: got %h, required 0000", d_rdata); else n_pass++;
        n_checks++; if (mem_start !== 1'b0) $display("FAIL rst_mem_start: got %b, required 0", mem_start); else n_pass++;
        n_checks++; if (mem_rwn !== 1'b1) $display("FAIL rst_mem_rwn: got %b, required 1", mem_rwn); else n_pass++;
        n_checks++; if (mem_address !== 8'h0) $display("FAIL rst_mem_address: got %h, required 00", mem_address); else n_pass++;
        n_checks++; if (mem_data_in !== 16'h0) $display("FAIL rst_mem_data_in: got %h, required 0000", mem_data_in); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_tie();
        int t0;
        bit seen;
        @(posedge clk); #1;
        t0 = cyc;
        d_req = 1'b1; d_rwn = 1'b1; d_addr = 8'd2;
        if_req = 1'b1; if_addr = 8'd10;
        exp_q.push_back('{1'b1, 16'h0005, t0 + 6});
        exp_q.push_back('{1'b0, 16'h9880, t0 + 13});
        wait_ack(1'b1, seen);
        d_req = 1'b0;
        n_checks++; if (seen !== 1'b1) $display("FAIL tie_data_ack: got no d_ack, required d_ack"); else n_pass++;
        wait_ack(1'b0, seen);
        if_req = 1'b0;
        n_checks++; if (seen !== 1'b1) $display("FAIL tie_fetch_ack: got no if_ack, required if_ack"); else n_pass++;
    endtask

    task automatic test_fetch();
        int t0, s0, da0;
        bit seen;
        @(posedge clk); #1;
        t0 = cyc; s0 = start_cnt; da0 = d_ack_cnt;
        if_req = 1'b1; if_addr = 8'd10;
        exp_q.push_back('{1'b0, 16'h9880, t0 + 6});
        @(negedge clk);
        n_checks++; if (mem_start !== 1'b0) $display("FAIL fetch_start_c0: got %b, required 0", mem_start); else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({mem_start, mem_rwn, mem_address} !== {1'b1, 1'b1, 8'd10})
            $display("FAIL fetch_issue_c1: got start=%b rwn=%b addr=%h, required 1 1 0a", mem_start, mem_rwn, mem_address);
        else n_pass++;
        wait_ack(1'b0, seen);
        if_req = 1'b0;
        n_checks++; if (seen !== 1'b1) $display("FAIL fetch_ack: got no if_ack, required if_ack"); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (start_cnt - s0 !== 1) $display("FAIL fetch_start_count: got %0d, required 1", start_cnt - s0); else n_pass++;
        n_checks++; if (d_ack_cnt !== da0) $display("FAIL fetch_no_d_ack: got %0d d_acks, required 0", d_ack_cnt - da0); else n_pass++;
    endtask

    task automatic test_load();
        int t0;
        bit seen;
        @(posedge clk); #1;
        t0 = cyc;
        d_req = 1'b1; d_rwn = 1'b1; d_addr = 8'd4;
        exp_q.push_back('{1'b1, 16'h000B, t0 + 4});
        wait_ack(1'b1, seen);
        d_req = 1'b0;
        n_checks++; if (seen !== 1'b1) $display("FAIL load_ack: got no d_ack, required d_ack"); else n_pass++;
    endtask

    task automatic test_store_load();
        int t0;
        bit seen;
        @(posedge clk); #1;
        t0 = cyc;
        d_req = 1'b1; d_rwn = 1'b0; d_addr = 8'd3; d_wdata = 16'h1234;
        exp_q.push_back('{1'b1, 16'h000B, t0 + 7});
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_start, mem_rwn, mem_address, mem_data_in} !== {1'b1, 1'b0, 8'd3, 16'h1234})
            $display("FAIL store_issue: got start=%b rwn=%b addr=%h wdata=%h, required 1 0 03 1234",
                     mem_start, mem_rwn, mem_address, mem_data_in);
        else n_pass++;
        wait_ack(1'b1, seen);
        d_req = 1'b0;
        n_checks++; if (seen !== 1'b1) $display("FAIL store_ack: got no d_ack, required d_ack"); else n_pass++;
        @(posedge clk); #1;
        t0 = cyc;
        d_req = 1'b1; d_rwn = 1'b1; d_addr = 8'd3; d_wdata = 16'h0;
        exp_q.push_back('{1'b1, 16'h1234, t0 + 7});
        wait_ack(1'b1, seen);
        d_req = 1'b0;
        n_checks++; if (seen !== 1'b1) $display("FAIL reload_ack: got no d_ack, required d_ack"); else n_pass++;
    endtask

    task automatic test_alternate();
        int t0, nf, nd;
        @(posedge clk); #1;
        t0 = cyc;
        if_req = 1'b1; if_addr = 8'd10;
        d_req = 1'b1; d_rwn = 1'b1; d_addr = 8'd4;
        exp_q.push_back('{1'b0, 16'h9880, t0 + 6});
        exp_q.push_back('{1'b1, 16'h000B, t0 + 11});
        exp_q.push_back('{1'b0, 16'h9880, t0 + 18});
        exp_q.push_back('{1'b0, 16'h9880, t0 + 25});
        nf = 0; nd = 0;
        for (int i = 0; i < 80 && nf < 3; i++) begin
            @(negedge clk);
            if (d_ack) begin
                d_req = 1'b0;
                nd++;
            end
            if (if_ack) begin
                nf++;
                if (nf == 3) if_req = 1'b0;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        n_checks++; if (nf !== 3) $display("FAIL alt_fetch_count: got %0d, required 3", nf); else n_pass++;
        n_checks++; if (nd !== 1) $display("FAIL alt_data_count: got %0d, required 1", nd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t0, ia0;
        bit seen;
        @(posedge clk); #1;
        t0 = cyc; ia0 = if_ack_cnt;
        if_req = 1'b1; if_addr = 8'd10;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if (if_ack !== 1'b0) $display("FAIL mid_if_ack: got %b, required 0", if_ack); else n_pass++;
        n_checks++; if (d_ack !== 1'b0) $display("FAIL mid_d_ack: got %b, required 0", d_ack); else n_pass++;
        n_checks++; if (if_rdata !== 16'h0) $display("FAIL mid_if_rdata: got %h, required 0000", if_rdata); else n_pass++;
        n_checks++; if (d_rdata !== 16'h0) $display("FAIL mid_d_rdata: got %h, required 0000", d_rdata); else n_pass++;
        n_checks++; if (mem_start !== 1'b0) $display("FAIL mid_mem_start: got %b, required 0", mem_start); else n_pass++;
        n_checks++; if (mem_rwn !== 1'b1) $display("FAIL mid_mem_rwn: got %b, required 1", mem_rwn); else n_pass++;
        n_checks++; if (mem_address !== 8'h0) $display("FAIL mid_mem_address: got %h, required 00", mem_address); else n_pass++;
        n_checks++; if (mem_data_in !== 16'h0) $display("FAIL mid_mem_data_in: got %h, required 0000", mem_data_in); else n_pass++;
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (if_ack_cnt !== ia0) $display("FAIL mid_no_ack: got %0d if_acks, required 0", if_ack_cnt - ia0); else n_pass++;
        @(posedge clk); #1;
        t0 = cyc;
        d_req = 1'b1; d_rwn = 1'b1; d_addr = 8'd2;
        exp_q.push_back('{1'b1, 16'h0005, t0 + 6});
        wait_ack(1'b1, seen);
        d_req = 1'b0;
        n_checks++; if (seen !== 1'b1) $display("FAIL post_reset_ack: got no d_ack, required d_ack"); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tie();
        test_fetch();
        test_load();
        test_store_load();
        test_alternate();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
